// File: rtl/awgn_snr_meter_if.sv
// Sample/result bundle for the AWGN SNR meter: start and sample-pair inputs,
// busy/done status and per-sample mean power results.
interface awgn_snr_meter_if #(
  parameter int unsigned BIT_W = 16
);
  logic                    start;
  logic                    in_valid;
  logic signed [BIT_W-1:0] x_ref_real;
  logic signed [BIT_W-1:0] x_ref_imagi;
  logic signed [BIT_W-1:0] y_in_real;
  logic signed [BIT_W-1:0] y_in_imagi;
  logic                    busy;
  logic                    done;
  logic [2*BIT_W-1:0]      sig_pow;
  logic [2*BIT_W+1:0]      err_pow;

  modport master (
    output start, in_valid, x_ref_real, x_ref_imagi, y_in_real, y_in_imagi,
    input  busy, done, sig_pow, err_pow
  );

  modport slave (
    input  start, in_valid, x_ref_real, x_ref_imagi, y_in_real, y_in_imagi,
    output busy, done, sig_pow, err_pow
  );
endinterface

// File: rtl/awgn_snr_meter.sv
// Windowed reference/error power meter: accumulates |x|^2 and |y-x|^2 over
// 2^LOG2_N valid samples and reports both as truncated per-sample means.
module awgn_snr_meter #(
  parameter int unsigned BIT_W  = 16,
  parameter int unsigned LOG2_N = 10
) (
  input logic             clock,
  input logic             reset,
  awgn_snr_meter_if.slave bus
);
  localparam int unsigned SW  = 2 * BIT_W;
  localparam int unsigned EW  = 2 * BIT_W + 2;
  localparam int unsigned ASW = SW + LOG2_N;
  localparam int unsigned AEW = EW + LOG2_N;

  typedef enum logic [1:0] {StIdle, StAccum, StFlush} state_e;

  state_e                  state_q;
  logic [LOG2_N-1:0]       cnt_q;
  logic                    s1_valid_q, s2_valid_q;
  logic signed [BIT_W-1:0] x_r_q, x_i_q;
  logic signed [BIT_W:0]   e_r_q, e_i_q;
  logic [SW-1:0]           p_s_q;
  logic [EW-1:0]           p_e_q;
  logic [ASW-1:0]          acc_s_q;
  logic [AEW-1:0]          acc_e_q;
  logic                    busy_q, done_q;
  logic [SW-1:0]           sig_pow_q;
  logic [EW-1:0]           err_pow_q;

  logic                    accept;
  logic signed [BIT_W:0]   e_r_d, e_i_d;
  logic signed [SW-1:0]    sq_x_r, sq_x_i;
  logic signed [EW-1:0]    sq_e_r, sq_e_i;
  logic [SW-1:0]           p_s_d;
  logic [EW-1:0]           p_e_d;

  always_comb begin
    accept = (state_q == StAccum) && bus.in_valid;
    e_r_d  = {bus.y_in_real[BIT_W-1], bus.y_in_real}
           - {bus.x_ref_real[BIT_W-1], bus.x_ref_real};
    e_i_d  = {bus.y_in_imagi[BIT_W-1], bus.y_in_imagi}
           - {bus.x_ref_imagi[BIT_W-1], bus.x_ref_imagi};
    // Operands sign-extended to the full product width so squares never wrap.
    sq_x_r = $signed({{BIT_W{x_r_q[BIT_W-1]}}, x_r_q}) * $signed({{BIT_W{x_r_q[BIT_W-1]}}, x_r_q});
    sq_x_i = $signed({{BIT_W{x_i_q[BIT_W-1]}}, x_i_q}) * $signed({{BIT_W{x_i_q[BIT_W-1]}}, x_i_q});
    sq_e_r = $signed({{(BIT_W+1){e_r_q[BIT_W]}}, e_r_q})
           * $signed({{(BIT_W+1){e_r_q[BIT_W]}}, e_r_q});
    sq_e_i = $signed({{(BIT_W+1){e_i_q[BIT_W]}}, e_i_q})
           * $signed({{(BIT_W+1){e_i_q[BIT_W]}}, e_i_q});
    p_s_d  = $unsigned(sq_x_r) + $unsigned(sq_x_i);
    p_e_d  = $unsigned(sq_e_r) + $unsigned(sq_e_i);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      x_r_q      <= '0;
      x_i_q      <= '0;
      e_r_q      <= '0;
      e_i_q      <= '0;
      p_s_q      <= '0;
      p_e_q      <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        x_r_q <= bus.x_ref_real;
        x_i_q <= bus.x_ref_imagi;
        e_r_q <= e_r_d;
        e_i_q <= e_i_d;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        p_s_q <= p_s_d;
        p_e_q <= p_e_d;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_s_q   <= '0;
      acc_e_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sig_pow_q <= '0;
      err_pow_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (s2_valid_q) begin
        acc_s_q <= acc_s_q + ASW'(p_s_q);
        acc_e_q <= acc_e_q + AEW'(p_e_q);
      end
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            acc_s_q <= '0;
            acc_e_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StAccum;
          end
        end
        StAccum: begin
          if (bus.in_valid) begin
            cnt_q <= cnt_q + LOG2_N'(1);
            if (cnt_q == '1) state_q <= StFlush;
          end
        end
        StFlush: begin
          // Both pipeline stages empty means the last product is in the accumulators.
          if (!s1_valid_q && !s2_valid_q) begin
            sig_pow_q <= SW'(acc_s_q >> LOG2_N);
            err_pow_q <= EW'(acc_e_q >> LOG2_N);
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.sig_pow = sig_pow_q;
  assign bus.err_pow = err_pow_q;
endmodule
